// File: rtl/debug_trace_pkg.sv
// Shared constants, state encoding and trigger compare for the debug trace capture block.
package debug_trace_pkg;

  localparam int TRACE_DEPTH  = 64;
  localparam int TRACE_ADDR_W = 6;

  typedef enum logic [1:0] {
    TRACE_IDLE  = 2'd0,
    TRACE_ARMED = 2'd1,
    TRACE_POST  = 2'd2,
    TRACE_DONE  = 2'd3
  } trace_state_t;

  function automatic logic trig_hit(input logic [31:0] data,
                                    input logic [31:0] value,
                                    input logic [31:0] mask);
    return ((data ^ value) & mask) == 32'h0;
  endfunction

endpackage

// File: rtl/debug_trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
// Only the read register is reset; storage is left uninitialised so it can map to a macro.
module debug_trace_ram
  import debug_trace_pkg::*;
#(
  parameter int DEPTH  = TRACE_DEPTH,
  parameter int ADDR_W = TRACE_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [31:0]       wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       rd_data
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read-during-write to the same address returns the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/debug_trace_capture.sv
// Debug port trace capture: mask/value trigger, post-trigger count, circular buffer readback.
//
// state        | meaning
// TRACE_IDLE   | no capture since reset, nothing written
// TRACE_ARMED  | writing every cycle, waiting for the trigger
// TRACE_POST   | trigger seen, writing the post-trigger samples
// TRACE_DONE   | capture stopped, buffer frozen for readback
module debug_trace_capture
  import debug_trace_pkg::*;
#(
  parameter int DEPTH  = TRACE_DEPTH,
  parameter int ADDR_W = TRACE_ADDR_W
) (
  input  logic              macCoreClk,
  input  logic              macCoreClkHardRst_n,
  input  logic [31:0]       debugPort,
  input  logic              traceStart,
  input  logic              traceStop,
  input  logic [31:0]       trigMask,
  input  logic [31:0]       trigValue,
  input  logic [ADDR_W-1:0] postTrigCnt,
  input  logic [ADDR_W-1:0] readAddr,
  output logic [31:0]       readData,
  output logic [1:0]        traceState,
  output logic              traceDone,
  output logic              traceWrap,
  output logic [ADDR_W-1:0] trigAddr,
  output logic [ADDR_W-1:0] wrPtr
);

  trace_state_t      state, state_nxt;
  logic [ADDR_W-1:0] post_cnt;
  logic              hit;
  logic              wr_en;

  assign hit = trig_hit(debugPort, trigValue, trigMask);

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) state <= TRACE_IDLE;
    else                      state <= state_nxt;
  end

  // Start has priority over stop and trigger in every state.
  always_comb begin
    state_nxt = state;
    if (traceStart) begin
      state_nxt = TRACE_ARMED;
    end else begin
      case (state)
        TRACE_ARMED: begin
          if (hit) state_nxt = (postTrigCnt == '0 || traceStop) ? TRACE_DONE : TRACE_POST;
          else if (traceStop) state_nxt = TRACE_DONE;
        end
        TRACE_POST: begin
          if (traceStop || post_cnt == ADDR_W'(1)) state_nxt = TRACE_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en      = !traceStart && (state == TRACE_ARMED || state == TRACE_POST);
    traceDone  = (state == TRACE_DONE);
    traceState = state;
  end

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) begin
      wrPtr     <= '0;
      traceWrap <= 1'b0;
      trigAddr  <= '0;
      post_cnt  <= '0;
    end else if (traceStart) begin
      wrPtr     <= '0;
      traceWrap <= 1'b0;
      post_cnt  <= '0;
    end else if (wr_en) begin
      wrPtr <= wrPtr + 1'b1;
      if (wrPtr == ADDR_W'(DEPTH - 1)) traceWrap <= 1'b1;
      if (state == TRACE_ARMED && hit) begin
        trigAddr <= wrPtr;
        post_cnt <= postTrigCnt;
      end else if (state == TRACE_POST) begin
        post_cnt <= post_cnt - 1'b1;
      end
    end
  end

  debug_trace_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (macCoreClk),
    .rst_n   (macCoreClkHardRst_n),
    .wr_en   (wr_en),
    .wr_addr (wrPtr),
    .wr_data (debugPort),
    .rd_addr (readAddr),
    .rd_data (readData)
  );

endmodule

// File: tb/tb_debug_trace_capture.sv
// Bench for debug_trace_capture: directed scenarios plus a randomized run against a capture model.
module tb_debug_trace_capture;

  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   debug_port;
  logic          trace_start, trace_stop;
  logic [31:0]   trig_mask, trig_value;
  logic [AW-1:0] post_trig_cnt, read_addr;
  logic [31:0]   read_data;
  logic [1:0]    trace_state;
  logic          trace_done, trace_wrap;
  logic [AW-1:0] trig_addr, wr_ptr;

  int tests_run = 0;
  int fails     = 0;

  // Capture model: mode uses the visible traceState numbering (0 idle, 1 armed, 2 post, 3 done).
  logic [31:0] m_mem [DEPTH];
  bit          m_valid [DEPTH];
  int          m_mode, m_ptr, m_trig, m_remain;
  bit          m_wrap;
  logic [31:0] m_rd;
  bit          m_rd_known;

  always #5 clk = ~clk;

  debug_trace_capture dut (
    .macCoreClk          (clk),
    .macCoreClkHardRst_n (rst_n),
    .debugPort           (debug_port),
    .traceStart          (trace_start),
    .traceStop           (trace_stop),
    .trigMask            (trig_mask),
    .trigValue           (trig_value),
    .postTrigCnt         (post_trig_cnt),
    .readAddr            (read_addr),
    .readData            (read_data),
    .traceState          (trace_state),
    .traceDone           (trace_done),
    .traceWrap           (trace_wrap),
    .trigAddr            (trig_addr),
    .wrPtr               (wr_ptr)
  );

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_trig = 0; m_remain = 0; m_wrap = 0;
    m_rd = 32'h0; m_rd_known = 1;
  endtask

  task automatic model_edge();
    bit hit;
    m_rd       = m_mem[read_addr];
    m_rd_known = m_valid[read_addr];
    if (trace_start) begin
      m_mode = 1; m_ptr = 0; m_wrap = 0; m_remain = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      m_mem[m_ptr]   = debug_port;
      m_valid[m_ptr] = 1;
      hit = ((debug_port ^ trig_value) & trig_mask) == 32'h0;
      if (m_mode == 1) begin
        if (hit) begin
          m_trig = m_ptr;
          if (post_trig_cnt == 0 || trace_stop) m_mode = 3;
          else begin m_mode = 2; m_remain = post_trig_cnt; end
        end else if (trace_stop) m_mode = 3;
      end else begin
        m_remain--;
        if (m_remain == 0 || trace_stop) m_mode = 3;
      end
      if (m_ptr == DEPTH - 1) m_wrap = 1;
      m_ptr = (m_ptr + 1) % DEPTH;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk); #1;
    trace_start = 0;
    trace_stop  = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; debug_port = 0; trace_start = 0; trace_stop = 0;
    trig_mask = 0; trig_value = 0; post_trig_cnt = 0; read_addr = 0;
    model_reset();
    #2;
    tests_run++;
    if (trace_state !== 2'd0 || wr_ptr !== '0 || trace_wrap !== 1'b0 || trace_done !== 1'b0 ||
        trig_addr !== '0 || read_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: state=%0d wrPtr=%0d wrap=%0b done=%0b trig=%0d rd=%0h, required all 0",
               trace_state, wr_ptr, trace_wrap, trace_done, trig_addr, read_data);
    end
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_post();
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'h1234; post_trig_cnt = 20;
    trace_start = 1; tick();
    debug_port = 32'h1234; tick();
    debug_port = 32'h0; tick();
    tests_run++;
    if (trace_state !== 2'd2) begin
      fails++; $display("FAIL mid_post_entry: state=%0d required 2", trace_state);
    end
    #2 rst_n = 0;
    model_reset();
    #1;
    tests_run++;
    if (trace_state !== 2'd0 || wr_ptr !== '0 || trace_wrap !== 1'b0 || trace_done !== 1'b0) begin
      fails++;
      $display("FAIL mid_post_reset: state=%0d wrPtr=%0d wrap=%0b done=%0b, required 0 0 0 0",
               trace_state, wr_ptr, trace_wrap, trace_done);
    end
    #2 rst_n = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      debug_port = 32'h1234; tick();
    end
    tests_run++;
    if (trace_state !== 2'd0 || wr_ptr !== '0) begin
      fails++; $display("FAIL idle_no_write: state=%0d wrPtr=%0d, required 0 0", trace_state, wr_ptr);
    end
  endtask

  task automatic test_basic_trigger();
    int k;
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'h0000_A5A5; post_trig_cnt = 3;
    trace_start = 1; tick();
    k = 0;
    while (!trace_done && k < 20) begin
      debug_port = 32'h0000_A5A0 + k; tick(); k++;
    end
    tests_run++;
    if (!trace_done || trig_addr !== 6'd5 || wr_ptr !== 6'd9) begin
      fails++;
      $display("FAIL basic_trigger: done=%0b trig=%0d wrPtr=%0d, required 1 5 9", trace_done, trig_addr, wr_ptr);
    end
    for (int a = 5; a <= 8; a++) begin
      read_addr = AW'(a); tick();
      tests_run++;
      if (read_data !== 32'h0000_A5A0 + a) begin
        fails++; $display("FAIL basic_read[%0d]: got %0h required %0h", a, read_data, 32'h0000_A5A0 + a);
      end
    end
  endtask

  task automatic test_zero_mask();
    trig_mask = 32'h0; post_trig_cnt = 0;
    trace_start = 1; tick();
    debug_port = 32'h0BAD_F00D; tick();
    tests_run++;
    if (trace_state !== 2'd3 || trig_addr !== '0 || wr_ptr !== 6'd1) begin
      fails++;
      $display("FAIL zero_mask: state=%0d trig=%0d wrPtr=%0d, required 3 0 1", trace_state, trig_addr, wr_ptr);
    end
    read_addr = 0; tick();
    tests_run++;
    if (read_data !== 32'h0BAD_F00D) begin
      fails++; $display("FAIL zero_mask_read: got %0h required 0badf00d", read_data);
    end
  endtask

  task automatic test_wrap();
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'hDEAD_0000; post_trig_cnt = 0;
    trace_start = 1; tick();
    for (int k = 0; k < 70; k++) begin
      debug_port = k; tick();
    end
    tests_run++;
    if (trace_state !== 2'd1) begin
      fails++; $display("FAIL wrap_holdoff: state=%0d required 1", trace_state);
    end
    debug_port = 32'hDEAD_0000; tick();
    tests_run++;
    if (trace_wrap !== 1'b1 || trig_addr !== 6'd6 || wr_ptr !== 6'd7 || trace_state !== 2'd3) begin
      fails++;
      $display("FAIL wrap: wrap=%0b trig=%0d wrPtr=%0d state=%0d, required 1 6 7 3",
               trace_wrap, trig_addr, wr_ptr, trace_state);
    end
    read_addr = 7; tick();
    tests_run++;
    if (read_data !== 32'd7) begin
      fails++; $display("FAIL wrap_oldest: got %0h required 7", read_data);
    end
    read_addr = 6; tick();
    tests_run++;
    if (read_data !== 32'hDEAD_0000) begin
      fails++; $display("FAIL wrap_trig_word: got %0h required dead0000", read_data);
    end
  endtask

  task automatic test_stop();
    trig_mask = 32'hFFFF_FFFF; trig_value = 32'hFFFF_FFFF; post_trig_cnt = 5;
    trace_start = 1; tick();
    for (int k = 0; k <= 10; k++) begin
      debug_port = 32'h5700_0000 + k;
      if (k == 10) trace_stop = 1;
      tick();
    end
    tests_run++;
    if (trace_state !== 2'd3 || wr_ptr !== 6'd11 || trig_addr !== 6'd6 || !trace_done) begin
      fails++;
      $display("FAIL stop: state=%0d wrPtr=%0d trig=%0d done=%0b, required 3 11 6 1",
               trace_state, wr_ptr, trig_addr, trace_done);
    end
    read_addr = 10; tick();
    tests_run++;
    if (read_data !== 32'h5700_000A) begin
      fails++; $display("FAIL stop_last_sample: got %0h required 5700000a", read_data);
    end
    trace_start = 1; trace_stop = 1; tick();
    tests_run++;
    if (trace_state !== 2'd1 || wr_ptr !== '0) begin
      fails++; $display("FAIL start_stop_same: state=%0d wrPtr=%0d, required 1 0", trace_state, wr_ptr);
    end
  endtask

  task automatic test_restart();
    debug_port = 32'h99; trace_stop = 1; tick();
    read_addr = 5; tick();
    tests_run++;
    if (trace_state !== 2'd3 || read_data !== 32'h5700_0005) begin
      fails++; $display("FAIL restart_pre: state=%0d rd=%0h, required 3 57000005", trace_state, read_data);
    end
    trace_start = 1; tick();
    tests_run++;
    if (trace_state !== 2'd1 || trace_done !== 1'b0 || trace_wrap !== 1'b0 || wr_ptr !== '0) begin
      fails++;
      $display("FAIL restart: state=%0d done=%0b wrap=%0b wrPtr=%0d, required 1 0 0 0",
               trace_state, trace_done, trace_wrap, wr_ptr);
    end
    for (int k = 0; k <= 5; k++) begin
      debug_port = 32'hBB00_0000 + k; tick();
      tests_run++;
      if (read_data !== 32'h5700_0005) begin
        fails++; $display("FAIL restart_old_word[%0d]: got %0h required 57000005", k, read_data);
      end
    end
    debug_port = 32'h0; tick();
    tests_run++;
    if (read_data !== 32'hBB00_0005) begin
      fails++; $display("FAIL restart_new_word: got %0h required bb000005", read_data);
    end
    trace_stop = 1; tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39) == 0) begin
        trace_start   = 1;
        trig_mask     = $urandom & 32'h7;
        trig_value    = $urandom;
        post_trig_cnt = ($urandom_range(1) == 0) ? AW'($urandom_range(3)) : AW'($urandom);
      end
      trace_stop = ($urandom_range(59) == 0);
      debug_port = $urandom;
      read_addr  = AW'($urandom);
      tick();
      tests_run++;
      if (trace_state !== 2'(m_mode) || wr_ptr !== AW'(m_ptr) || trace_wrap !== m_wrap ||
          trig_addr !== AW'(m_trig) || trace_done !== (m_mode == 3)) begin
        fails++;
        $display("FAIL random_ctrl[%0d]: state=%0d wrPtr=%0d wrap=%0b trig=%0d done=%0b, required %0d %0d %0b %0d %0b",
                 c, trace_state, wr_ptr, trace_wrap, trig_addr, trace_done,
                 m_mode, m_ptr, m_wrap, m_trig, (m_mode == 3));
      end
      if (m_rd_known) begin
        tests_run++;
        if (read_data !== m_rd) begin
          fails++; $display("FAIL random_read[%0d]: got %0h required %0h", c, read_data, m_rd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_post();
    test_basic_trigger();
    test_zero_mask();
    test_wrap();
    test_stop();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
